// File: rtl/bcd_digit_entry_if.sv
// Digit-entry bundle: raw buttons and switches in, BCD echo and binary result out.
// ENTRY_BACKSPACE_EN adds the backspace_btn signal.
interface bcd_digit_entry_if #(
   parameter int unsigned NUM_DIGITS = 5,
   parameter int unsigned OUT_WIDTH  = 20
);
   logic [3:0]              digit_in;
   logic                    enter_btn;
   logic                    clear_btn;
`ifdef ENTRY_BACKSPACE_EN
   logic                    backspace_btn;
`endif
   logic [4*NUM_DIGITS-1:0] bcd_digits;
   logic [2:0]              digit_count;
   logic [OUT_WIDTH-1:0]    value_out;
   logic                    value_valid;
   logic                    err;

`ifdef ENTRY_BACKSPACE_EN
   modport master (output digit_in, enter_btn, clear_btn, backspace_btn,
                   input  bcd_digits, digit_count, value_out, value_valid, err);
   modport slave  (input  digit_in, enter_btn, clear_btn, backspace_btn,
                   output bcd_digits, digit_count, value_out, value_valid, err);
`else
   modport master (output digit_in, enter_btn, clear_btn,
                   input  bcd_digits, digit_count, value_out, value_valid, err);
   modport slave  (input  digit_in, enter_btn, clear_btn,
                   output bcd_digits, digit_count, value_out, value_valid, err);
`endif
endinterface

// File: rtl/bcd_digit_entry.sv
// Keyed decimal entry: debounced buttons shift digits into a BCD register that an
// iterative x10 FSM converts to binary. Define ENTRY_BACKSPACE_EN to add a backspace button.
module bcd_digit_entry #(
   parameter int unsigned NUM_DIGITS      = 5,
   parameter int unsigned OUT_WIDTH       = 20,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             rst_n,
   bcd_digit_entry_if.slave bus
);
   localparam int unsigned BW = 4 * NUM_DIGITS;
   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
   localparam logic [2:0]    COUNT_MAX = 3'(NUM_DIGITS);
   localparam int unsigned B_ENTER = 0;
   localparam int unsigned B_CLEAR = 1;
`ifdef ENTRY_BACKSPACE_EN
   localparam int unsigned B_BACK  = 2;
   localparam int unsigned NB      = 3;
`else
   localparam int unsigned NB      = 2;
`endif

   typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_e;

   logic [NB-1:0]        btn_raw, sync1_q, sync2_q, db_q, press_q;
   logic [CW-1:0]        cnt_q [NB];
   state_e               state_q;
   logic [BW-1:0]        bcd_q;
   logic [2:0]           count_q;
   logic [OUT_WIDTH-1:0] acc_q, acc_d, value_q;
   logic [IW-1:0]        idx_q;
   logic                 valid_q, err_q, pend_q, pend_is_bsp;
   logic                 ent_ev, clr_ev, bsp_ev, do_ent, do_bsp, ent_ok, bsp_ok;
   logic [3:0]           cur_digit;

   always_comb begin
      btn_raw          = '1;
      btn_raw[B_ENTER] = bus.enter_btn;
      btn_raw[B_CLEAR] = bus.clear_btn;
`ifdef ENTRY_BACKSPACE_EN
      btn_raw[B_BACK]  = bus.backspace_btn;
`endif
   end

   // Buttons idle high, so the conditioning chain resets to the released level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
         db_q    <= '1;
         press_q <= '0;
         for (int unsigned b = 0; b < NB; b++) cnt_q[b] <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         for (int unsigned b = 0; b < NB; b++) begin
            press_q[b] <= 1'b0;
            if (sync2_q[b] != db_q[b]) begin
               if (cnt_q[b] == CNT_LAST) begin
                  db_q[b]    <= sync2_q[b];
                  cnt_q[b]   <= '0;
                  press_q[b] <= db_q[b];
               end else begin
                  cnt_q[b] <= cnt_q[b] + 1'b1;
               end
            end else begin
               cnt_q[b] <= '0;
            end
         end
      end
   end

   assign ent_ev = press_q[B_ENTER];
   assign clr_ev = press_q[B_CLEAR];
`ifdef ENTRY_BACKSPACE_EN
   logic pend_bsp_q;
   assign bsp_ev      = press_q[B_BACK];
   assign pend_is_bsp = pend_bsp_q;
`else
   assign bsp_ev      = 1'b0;
   assign pend_is_bsp = 1'b0;
`endif

   // A queued event takes precedence over a fresh one arriving in the same IDLE cycle.
   always_comb begin
      do_ent = 1'b0;
      do_bsp = 1'b0;
      if (state_q == IDLE) begin
         if (pend_q) begin
            do_bsp = pend_is_bsp;
            do_ent = !pend_is_bsp;
         end else begin
            do_bsp = bsp_ev;
            do_ent = ent_ev && !bsp_ev;
         end
      end
      ent_ok = do_ent && (bus.digit_in <= 4'd9) && (count_q < COUNT_MAX);
      bsp_ok = do_bsp && (count_q != 3'd0);
      cur_digit = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
         if (idx_q == IW'(NUM_DIGITS - 1 - i)) cur_digit = bcd_q[4*i +: 4];
      acc_d = (acc_q << 3) + (acc_q << 1) + OUT_WIDTH'(cur_digit);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bcd_q   <= '0;
         count_q <= '0;
         acc_q   <= '0;
         value_q <= '0;
         idx_q   <= '0;
         valid_q <= 1'b1;
         err_q   <= 1'b0;
         pend_q  <= 1'b0;
`ifdef ENTRY_BACKSPACE_EN
         pend_bsp_q <= 1'b0;
`endif
      end else if (clr_ev) begin
         state_q <= IDLE;
         bcd_q   <= '0;
         count_q <= '0;
         acc_q   <= '0;
         value_q <= '0;
         idx_q   <= '0;
         valid_q <= 1'b1;
         err_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               pend_q <= 1'b0;
               if (ent_ok || bsp_ok) begin
                  bcd_q   <= ent_ok ? ((bcd_q << 4) | BW'(bus.digit_in)) : (bcd_q >> 4);
                  count_q <= ent_ok ? (count_q + 3'd1) : (count_q - 3'd1);
                  err_q   <= 1'b0;
                  valid_q <= 1'b0;
                  acc_q   <= '0;
                  idx_q   <= '0;
                  state_q <= CONVERT;
               end else if (do_ent) begin
                  err_q <= 1'b1;
               end
            end
            CONVERT: begin
               acc_q <= acc_d;
               idx_q <= idx_q + 1'b1;
               // Result is published on entry to DONE so value_valid rises with it.
               if (idx_q == IDX_LAST) begin
                  value_q <= acc_d;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
         if ((state_q != IDLE) && !pend_q && (ent_ev || bsp_ev)) begin
            pend_q <= 1'b1;
`ifdef ENTRY_BACKSPACE_EN
            pend_bsp_q <= bsp_ev;
`endif
         end
      end
   end

   assign bus.bcd_digits  = bcd_q;
   assign bus.digit_count = count_q;
   assign bus.value_out   = value_q;
   assign bus.value_valid = valid_q;
   assign bus.err         = err_q;
endmodule

// File: tb/tb_bcd_digit_entry.sv
// Bench for bcd_digit_entry: directed entry scenarios plus random button activity,
// checked every cycle against a behavioural model of debounce, entry and conversion.
module tb_bcd_digit_entry;
   localparam int N  = 5;
   localparam int OW = 20;
   localparam int DB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   bcd_digit_entry_if #(.NUM_DIGITS(N), .OUT_WIDTH(OW)) bus ();
   bcd_digit_entry #(.NUM_DIGITS(N), .OUT_WIDTH(OW), .DEBOUNCE_CYCLES(DB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   int low_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Model state: raw button history (newest in bit 0), debounced levels, entered digits.
   logic [31:0] he, hc;
   bit lvl_e, lvl_c, ev_e, ev_c, cur_e, cur_c;
   int unsigned m_dig[$];
   int m_rem;
   bit m_pend, m_err, m_valid;
   int unsigned m_value;

   function automatic int unsigned m_decimal();
      int unsigned v = 0;
      foreach (m_dig[i]) v = v * 10 + m_dig[i];
      return v;
   endfunction

   function automatic logic [31:0] m_bcd();
      logic [31:0] r = '0;
      foreach (m_dig[i]) r = (r << 4) | 32'(m_dig[i]);
      return r;
   endfunction

   task automatic model_clear();
      m_dig.delete();
      m_rem = 0; m_pend = 0; m_err = 0; m_valid = 1; m_value = 0;
   endtask

   task automatic model_step();
      if (!rst_n) begin
         he = '1; hc = '1; lvl_e = 1; lvl_c = 1; ev_e = 0; ev_c = 0;
         model_clear();
         return;
      end
      cur_e = ev_e;
      cur_c = ev_c;
      if (cur_c) begin
         model_clear();
      end else if (m_rem > 0) begin
         if (cur_e) m_pend = 1;
         m_rem--;
         if (m_rem == 1) begin
            m_value = m_decimal();
            m_valid = 1;
         end
      end else if (m_pend || cur_e) begin
         m_pend = 0;
         if (bus.digit_in <= 4'd9 && m_dig.size() < N) begin
            m_dig.push_back(32'(bus.digit_in));
            m_err = 0; m_valid = 0; m_rem = N + 1;
         end else begin
            m_err = 1;
         end
      end
      // Debounced level flips once the last DB synchronised samples (raw delayed by 2) all disagree.
      he = {he[30:0], bus.enter_btn};
      hc = {hc[30:0], bus.clear_btn};
      ev_e = 0; ev_c = 0;
      if (he[DB+1:2] == {DB{~lvl_e}}) begin ev_e = lvl_e; lvl_e = ~lvl_e; end
      if (hc[DB+1:2] == {DB{~lvl_c}}) begin ev_c = lvl_c; lvl_c = ~lvl_c; end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      check("bcd_digits",  32'(bus.bcd_digits),  m_bcd());
      check("digit_count", 32'(bus.digit_count), 32'(m_dig.size()));
      check("value_out",   32'(bus.value_out),   m_value);
      check("value_valid", 32'(bus.value_valid), 32'(m_valid));
      check("err",         32'(bus.err),         32'(m_err));
      if (!bus.value_valid) low_cnt++;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] d, input bit e, input bit c);
      @(negedge clk);
      bus.digit_in = d;
      if (e) bus.enter_btn = 1'b0;
      if (c) bus.clear_btn = 1'b0;
      idle(8);
      bus.enter_btn = 1'b1;
      bus.clear_btn = 1'b1;
      idle(16);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_bcd"},   32'(bus.bcd_digits),  32'h0);
      check({tag, "_count"}, 32'(bus.digit_count), 32'd0);
      check({tag, "_value"}, 32'(bus.value_out),   32'd0);
      check({tag, "_valid"}, 32'(bus.value_valid), 32'd1);
      check({tag, "_err"},   32'(bus.err),         32'd0);
   endtask

   initial begin
      int k;
      bus.digit_in  = 4'd0;
      bus.enter_btn = 1'b1;
      bus.clear_btn = 1'b1;
`ifdef ENTRY_BACKSPACE_EN
      bus.backspace_btn = 1'b1;
`endif
      rst_n = 1'b0;
      idle(3);
      check_reset_values("por");
      #3 rst_n = 1'b1;
      idle(2);

      // Digits 1,2,3 and conversion latency of the last one
      press(4'd1, 1, 0);
      press(4'd2, 1, 0);
      low_cnt = 0;
      press(4'd3, 1, 0);
      check("t2_bcd",     32'(bus.bcd_digits),  32'h00123);
      check("t2_count",   32'(bus.digit_count), 32'd3);
      check("t2_value",   32'(bus.value_out),   32'd123);
      check("t2_model",   m_value,              32'd123);
      check("t2_lowcyc",  32'(low_cnt),         32'd5);

      // Full register of nines, then one too many
      press(4'd0, 0, 1);
      repeat (5) press(4'd9, 1, 0);
      check("t3_value",   32'(bus.value_out),   32'h1869F);
      check("t3_model",   m_value,              32'd99999);
      check("t3_count",   32'(bus.digit_count), 32'd5);
      check("t3_err0",    32'(bus.err),         32'd0);
      press(4'd9, 1, 0);
      check("t3_err1",    32'(bus.err),         32'd1);
      check("t3_bcd",     32'(bus.bcd_digits),  32'h99999);
      check("t3_value2",  32'(bus.value_out),   32'd99999);

      // Non-decimal digit rejected, next good digit clears err
      press(4'd0, 0, 1);
      press(4'd1, 1, 0);
      press(4'hA, 1, 0);
      check("t4_err1",    32'(bus.err),         32'd1);
      check("t4_bcd",     32'(bus.bcd_digits),  32'h00001);
      press(4'd7, 1, 0);
      check("t4_err0",    32'(bus.err),         32'd0);
      check("t4_bcd2",    32'(bus.bcd_digits),  32'h00017);
      check("t4_value",   32'(bus.value_out),   32'd17);

      // Bouncing button: short glitches ignored, final hold accepted once
      press(4'd0, 0, 1);
      bus.digit_in = 4'd6;
      for (int i = 0; i < 5; i++) begin
         bus.enter_btn = 1'b0; idle(2);
         bus.enter_btn = 1'b1; idle(2);
      end
      press(4'd6, 1, 0);
      check("t5_count",   32'(bus.digit_count), 32'd1);
      check("t5_bcd",     32'(bus.bcd_digits),  32'h00006);

      // Clear and enter landing together: clear wins
      press(4'd0, 0, 1);
      press(4'd4, 1, 0);
      press(4'd5, 1, 0);
      check("t6_pre",     32'(bus.bcd_digits),  32'h00045);
      press(4'd8, 1, 1);
      check_reset_values("t6");
      idle(20);
      check("t6_nopend",  32'(bus.digit_count), 32'd0);

      // Random button activity and switch changes
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if ($urandom_range(5, 0) == 0) bus.enter_btn = ~bus.enter_btn;
         if (bus.clear_btn) begin
            if ($urandom_range(79, 0) == 0) bus.clear_btn = 1'b0;
         end else if ($urandom_range(4, 0) == 0) begin
            bus.clear_btn = 1'b1;
         end
         if ($urandom_range(9, 0) == 0) bus.digit_in = 4'($urandom_range(12, 0));
      end
      bus.enter_btn = 1'b1;
      bus.clear_btn = 1'b1;
      idle(20);

      // Asynchronous reset in the middle of a conversion
      press(4'd0, 0, 1);
      @(negedge clk);
      bus.digit_in  = 4'd3;
      bus.enter_btn = 1'b0;
      k = 0;
      while (bus.value_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("t1_busy",    32'(bus.value_valid), 32'd0);
      #3 rst_n = 1'b0;
      #1 check_reset_values("t1");
      bus.enter_btn = 1'b1;
      idle(2);
      #3 rst_n = 1'b1;
      idle(20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
